// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC flit format: flit width, type codes, field
//               positions and flit builders used by injection, router and
//               ejection logic.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int FLIT_W = 64;

  // Flit type codes carried in the top two bits
  localparam logic [1:0] c_ft_idle = 2'b00;
  localparam logic [1:0] c_ft_head = 2'b01;
  localparam logic [1:0] c_ft_body = 2'b10;
  localparam logic [1:0] c_ft_tail = 2'b11;

  // Field bit positions
  localparam int c_type_hi = 63;
  localparam int c_type_lo = 62;
  localparam int c_dx_hi   = 61;
  localparam int c_dx_lo   = 60;
  localparam int c_dy_hi   = 59;
  localparam int c_dy_lo   = 58;
  localparam int c_sx_hi   = 57;
  localparam int c_sx_lo   = 56;
  localparam int c_sy_hi   = 55;
  localparam int c_sy_lo   = 54;
  localparam int c_len_hi  = 53;
  localparam int c_len_lo  = 50;
  localparam int c_id_hi   = 47;
  localparam int c_id_lo   = 40;
  localparam int c_seq_hi  = 39;
  localparam int c_seq_lo  = 32;
  localparam int c_data_hi = 31;
  localparam int c_data_lo = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } inj_state_t;

  // Head flit: routing info plus packet length and id; unused bits zero
  function automatic logic [63:0] make_head(input logic [1:0] dx, input logic [1:0] dy,
                                            input logic [1:0] sx, input logic [1:0] sy,
                                            input logic [3:0] len, input logic [7:0] id);
    logic [63:0] f;
    f = '0;
    f[c_type_hi:c_type_lo] = c_ft_head;
    f[c_dx_hi:c_dx_lo]     = dx;
    f[c_dy_hi:c_dy_lo]     = dy;
    f[c_sx_hi:c_sx_lo]     = sx;
    f[c_sy_hi:c_sy_lo]     = sy;
    f[c_len_hi:c_len_lo]   = len;
    f[c_id_hi:c_id_lo]     = id;
    return f;
  endfunction

  // Body or tail flit carrying one payload word
  function automatic logic [63:0] make_body(input logic last, input logic [7:0] id,
                                            input logic [7:0] seq, input logic [31:0] data);
    logic [63:0] f;
    f = '0;
    f[c_type_hi:c_type_lo] = last ? c_ft_tail : c_ft_body;
    f[c_id_hi:c_id_lo]     = id;
    f[c_seq_hi:c_seq_lo]   = seq;
    f[c_data_hi:c_data_lo] = data;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Tracks free slots in the router PE-input buffer. Starts full,
//               saturates at CREDITS, and a same-edge return/consume nets out.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_counter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_credit,
  input  logic i_consume,
  output logic o_available
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(CREDITS);

  logic [CNT_W-1:0] r_count;

  // Count returned credits up (saturating) and emitted flits down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_full;
    end else if (i_credit && !i_consume) begin
      if (r_count != c_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_consume && !i_credit) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_available = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/net_inject.sv
`default_nettype none
// ============================================================================
// Module      : net_inject
// Description : Network injection interface. Turns packet requests plus a
//               stream of payload words into head/body/tail flits for the
//               router PE input, under credit-based flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module net_inject
  import noc_pkg::*;
#(
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int X_COORD = 1,
  parameter int Y_COORD = 1,
  parameter int MAX_LEN = 8,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_dest_x,
  input  logic [1:0]        req_dest_y,
  input  logic [3:0]        req_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [31:0]       data_in,
  input  logic              credit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              err_len,
  output logic              busy
);

  inj_state_t        r_state;
  inj_state_t        w_state_nxt;
  logic [1:0]        r_dest_x;
  logic [1:0]        r_dest_y;
  logic [3:0]        r_len;
  logic [3:0]        r_seq;
  logic [7:0]        r_next_id;
  logic [7:0]        r_cur_id;
  logic [FLIT_W-1:0] r_flit;
  logic              r_err;

  logic              w_credit_ok;
  logic              w_len_bad;
  logic              w_emit;
  logic              w_accept;
  logic              w_reject;
  logic              w_word;
  logic              w_last;
  logic [FLIT_W-1:0] w_flit_nxt;

  credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk         (clk),
    .rst         (rst),
    .i_credit    (credit_in),
    .i_consume   (w_emit),
    .o_available (w_credit_ok)
  );

  assign w_len_bad = (req_len == 4'd0) || (req_len > 4'(MAX_LEN));

  // Next state and the flit to register this cycle, if any
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_word      = 1'b0;
    w_last      = 1'b0;
    w_flit_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_len_bad) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            if (w_credit_ok) begin
              // Head goes out straight from the request using the fresh id
              w_emit      = 1'b1;
              w_flit_nxt  = FLIT_W'(make_head(req_dest_x, req_dest_y, 2'(X_COORD),
                                              2'(Y_COORD), req_len, r_next_id));
              w_state_nxt = ST_PAYLOAD;
            end else begin
              w_state_nxt = ST_HEAD;
            end
          end
        end
      end
      ST_HEAD: begin
        if (w_credit_ok) begin
          w_emit      = 1'b1;
          w_flit_nxt  = FLIT_W'(make_head(r_dest_x, r_dest_y, 2'(X_COORD),
                                          2'(Y_COORD), r_len, r_cur_id));
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_credit_ok && data_valid) begin
          w_word     = 1'b1;
          w_emit     = 1'b1;
          w_last     = (r_seq == (r_len - 4'd1));
          w_flit_nxt = FLIT_W'(make_body(w_last, r_cur_id, {4'd0, r_seq}, data_in));
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output flit, error pulse, captured request fields and packet id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit    <= '0;
      r_err     <= 1'b0;
      r_dest_x  <= '0;
      r_dest_y  <= '0;
      r_len     <= '0;
      r_seq     <= '0;
      r_next_id <= '0;
      r_cur_id  <= '0;
    end else begin
      r_flit <= w_flit_nxt;
      r_err  <= w_reject;
      if (w_accept) begin
        r_dest_x  <= req_dest_x;
        r_dest_y  <= req_dest_y;
        r_len     <= req_len;
        r_seq     <= '0;
        r_cur_id  <= r_next_id;
        r_next_id <= r_next_id + 8'd1;
      end else if (w_word) begin
        r_seq <= r_seq + 4'd1;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign data_ready = (r_state == ST_PAYLOAD) && w_credit_ok;
  assign busy       = (r_state != ST_IDLE);
  assign flit_out   = r_flit;
  assign err_len    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_net_inject.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_inject
// Description : Self-checking bench for net_inject with a packet-level
//               reference model of flits, credits and packet ids.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_inject;

  localparam int FLIT_W  = 64;
  localparam int X_COORD = 1;
  localparam int Y_COORD = 1;
  localparam int MAX_LEN = 8;
  localparam int CREDITS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_dest_x = '0;
  logic [1:0]        req_dest_y = '0;
  logic [3:0]        req_len = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic [31:0]       data_in = '0;
  logic              credit_in = 1'b0;
  logic [FLIT_W-1:0] flit_out;
  logic              err_len;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int model_credits = CREDITS;
  int model_next_id = 0;

  net_inject #(
    .FLIT_W  (FLIT_W),
    .X_COORD (X_COORD),
    .Y_COORD (Y_COORD),
    .MAX_LEN (MAX_LEN),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest_x (req_dest_x),
    .req_dest_y (req_dest_y),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .credit_in  (credit_in),
    .flit_out   (flit_out),
    .err_len    (err_len),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_head(input int dx, input int dy, input int len, input int id);
    logic [63:0] f;
    int sx;
    int sy;
    sx = X_COORD;
    sy = Y_COORD;
    f = '0;
    f[63:62] = 2'b01;
    f[61:60] = dx[1:0];
    f[59:58] = dy[1:0];
    f[57:56] = sx[1:0];
    f[55:54] = sy[1:0];
    f[53:50] = len[3:0];
    f[47:40] = id[7:0];
    return f;
  endfunction

  function automatic logic [63:0] exp_body(input int id, input int seq, input logic [31:0] data,
                                           input bit last);
    logic [63:0] f;
    f = '0;
    f[63:62] = last ? 2'b11 : 2'b10;
    f[47:40] = id[7:0];
    f[39:32] = seq[7:0];
    f[31:0]  = data;
    return f;
  endfunction

  task automatic do_reset(input string name);
    req_valid  = 1'b0;
    data_valid = 1'b0;
    credit_in  = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (flit_out !== '0 || busy !== 1'b0 || err_len !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s reset outputs got flit=%h busy=%b err=%b rdy=%b exp flit=0 busy=0 err=0 rdy=1",
               name, flit_out, busy, err_len, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_credits = CREDITS;
    model_next_id = 0;
  endtask

  task automatic give_credits(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid  = 1'b0;
      data_valid = 1'b0;
      credit_in  = 1'b1;
      @(negedge clk);
      if (model_credits < CREDITS) model_credits++;
      checks++;
      if (flit_out !== '0) begin
        failures++;
        $display("FAIL give_credits flit_out got=%h exp=0", flit_out);
      end
    end
    credit_in = 1'b0;
  endtask

  // Drives one packet cycle by cycle from a negedge, predicting every flit.
  // abort_after >= 0 returns early once that many payload words have been seen.
  task automatic run_packet(input int dx, input int dy, input int len, input int gap_pct,
                            input int cred_pct, input bit fixed_data, input int abort_after,
                            input string name, output int n_cycles);
    logic [31:0] words [16];
    logic [63:0] exp;
    int phase;
    int k;
    int id;
    int stall;
    bit emit;
    bit cin;
    bit dv;
    for (int i = 0; i < 16; i++) words[i] = fixed_data ? (32'hAAAA0001 + i) : $urandom;
    phase = 0;
    k = 0;
    id = 0;
    stall = 0;
    n_cycles = 0;
    while (phase != 3 && n_cycles < 600) begin
      n_cycles++;
      emit = 1'b0;
      exp = '0;
      cin = ($urandom_range(99) < cred_pct) || (model_credits == 0 && stall >= 3);
      dv = ($urandom_range(99) >= gap_pct);
      credit_in = cin;
      if (phase == 2) begin
        data_valid = dv;
        data_in    = words[k];
      end else begin
        data_valid = 1'($urandom_range(1));
        data_in    = $urandom;
      end
      if (phase == 0) begin
        req_valid  = 1'b1;
        req_dest_x = 2'(dx);
        req_dest_y = 2'(dy);
        req_len    = 4'(len);
      end else begin
        req_valid  = 1'($urandom_range(1));
        req_dest_x = 2'($urandom);
        req_dest_y = 2'($urandom);
        req_len    = 4'($urandom);
      end
      #1;
      case (phase)
        0: begin
          checks++;
          if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s req_ready idle got=%b exp=1", name, req_ready);
          end
          id = model_next_id;
          model_next_id = (model_next_id + 1) % 256;
          if (model_credits > 0) begin
            emit = 1'b1;
            exp = exp_head(dx, dy, len, id);
            phase = 2;
          end else begin
            phase = 1;
          end
        end
        1: begin
          checks++;
          if (req_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s head_wait got rdy=%b busy=%b exp rdy=0 busy=1", name, req_ready, busy);
          end
          if (model_credits > 0) begin
            emit = 1'b1;
            exp = exp_head(dx, dy, len, id);
            phase = 2;
          end
        end
        default: begin
          checks++;
          if (data_ready !== (model_credits > 0) || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s data_ready got=%b exp=%b busy=%b credits=%0d",
                     name, data_ready, (model_credits > 0), busy, model_credits);
          end
          if (model_credits > 0 && dv) begin
            emit = 1'b1;
            exp = exp_body(id, k, words[k], (k == len - 1));
            k++;
            if (k == len) phase = 3;
          end
        end
      endcase
      if (emit && !cin) model_credits--;
      else if (!emit && cin && model_credits < CREDITS) model_credits++;
      if (model_credits == 0) stall++;
      else stall = 0;
      @(negedge clk);
      checks++;
      if (flit_out !== exp || err_len !== 1'b0) begin
        failures++;
        $display("FAIL %s flit_out cycle %0d got=%h err=%b exp=%h err=0", name, n_cycles, flit_out, err_len, exp);
      end
      if (abort_after >= 0 && phase == 2 && k == abort_after) return;
    end
    req_valid  = 1'b0;
    data_valid = 1'b0;
    credit_in  = 1'b0;
    checks++;
    if (phase != 3) begin
      failures++;
      $display("FAIL %s timeout phase=%0d words=%0d exp all %0d words", name, phase, k, len);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s end_idle got busy=%b rdy=%b exp busy=0 rdy=1", name, busy, req_ready);
    end
  endtask

  task automatic test_reset();
    do_reset("test_reset");
  endtask

  task automatic test_basic();
    int n;
    do_reset("basic");
    run_packet(3, 2, 2, 0, 0, 1'b1, -1, "basic", n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL basic consecutive cycles got=%0d exp=3", n);
    end
  endtask

  task automatic test_credit_stall();
    int n;
    give_credits(4);
    run_packet(0, 3, 8, 0, 0, 1'b0, -1, "credit_stall", n);
  endtask

  task automatic test_err_len();
    int n;
    int lens [2];
    lens[0] = 0;
    lens[1] = MAX_LEN + 1;
    do_reset("err_len");
    for (int i = 0; i < 2; i++) begin
      req_valid  = 1'b1;
      req_len    = 4'(lens[i]);
      req_dest_x = 2'($urandom);
      req_dest_y = 2'($urandom);
      credit_in  = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (err_len !== 1'b1 || flit_out !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL err_len len=%0d pulse got err=%b flit=%h busy=%b exp err=1 flit=0 busy=0",
                 lens[i], err_len, flit_out, busy);
      end
      @(negedge clk);
      checks++;
      if (err_len !== 1'b0 || flit_out !== '0) begin
        failures++;
        $display("FAIL err_len len=%0d after got err=%b flit=%h exp err=0 flit=0", lens[i], err_len, flit_out);
      end
    end
    run_packet(1, 1, 3, 0, 0, 1'b0, -1, "after_err", n);
  endtask

  task automatic test_same_edge();
    int n;
    do_reset("same_edge");
    run_packet(1, 0, 2, 0, 0, 1'b0, -1, "drain", n);
    run_packet(0, 3, 3, 0, 100, 1'b0, -1, "same_edge", n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL same_edge no_stall cycles got=%0d exp=4", n);
    end
  endtask

  task automatic test_id_wrap();
    int n;
    do_reset("id_wrap");
    for (int p = 0; p < 257; p++) begin
      run_packet($urandom_range(3), $urandom_range(3), 1, 0, 100, 1'b0, -1, "id_wrap", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset("reset_mid");
    run_packet(2, 1, 4, 0, 0, 1'b0, 2, "reset_mid", n);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (flit_out !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid async got flit=%h busy=%b rdy=%b exp flit=0 busy=0 rdy=1",
               flit_out, busy, req_ready);
    end
    req_valid  = 1'b0;
    data_valid = 1'b0;
    credit_in  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (flit_out !== '0) begin
      failures++;
      $display("FAIL reset_mid no_tail got=%h exp=0", flit_out);
    end
    rst = 1'b0;
    model_credits = CREDITS;
    model_next_id = 0;
    run_packet(3, 3, 2, 0, 0, 1'b0, -1, "after_reset_mid", n);
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 12; p++) begin
      run_packet($urandom_range(3), $urandom_range(3), $urandom_range(MAX_LEN, 1), 30, 35,
                 1'b0, -1, "random", n);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_credit_stall();
    test_err_len();
    test_same_edge();
    test_id_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
